prng_stream_ctrl: RTL
=====================

Name: prng_stream_ctrl

Overview:
- Initiator-side controller for the `prng` core. It drives `in_seed`/`in_mod`/`in_ready`, collects `out_rng`/`out_ready`, and serialises each 96-bit PRNG word into DIGIT-wide chunks for downstream consumers (random vector/ring element generation) over a valid/accept handshake.
- It replaces the hand-driven seed/request sequencing with a synthesizable FSM that supports reseeding and length-bounded bursts.

Parameters:
- W, 96: PRNG word width; must equal the `prng` `out_rng`/`in_seed` width.
- DIGIT, 32: output chunk width; W must be an integer multiple of DIGIT.
- LEN_W, 16: width of the burst-length and fetch counters.

Ports:
- clk  input  1  system clock, rising edge.
- rst_b  input  1  synchronous active-low reset.
- cfg_seed  input  W  seed value, sampled on cfg_seed_load.
- cfg_seed_load  input  1  reseed request pulse; honoured only while busy=0.
- req_start  input  1  burst request pulse; honoured only while busy=0.
- req_len  input  LEN_W  number of DIGIT chunks to deliver; sampled with req_start.
- busy  output  1  high in every state except IDLE.
- prng_seed  output  W  to `prng` `in_seed`.
- prng_mod  output  1  to `prng` `in_mod`; 1 = update seed.
- prng_start  output  1  to `prng` `in_ready`; one-cycle pulse.
- prng_rng  input  W  from `prng` `out_rng`.
- prng_ready  input  1  from `prng` `out_ready`.
- out_data  output  DIGIT  current chunk, which is buffer[DIGIT-1:0].
- out_valid  output  1  out_data valid.
- out_accept  input  1  downstream ready; a transfer occurs when out_valid & out_accept.
- out_last  output  1  high with the final chunk of a burst.
- fetch_cnt  output  LEN_W  count of PRNG words captured since reset; wraps.

Behaviour:
- Reset (rst_b=0 at a rising edge):
  - FSM goes to IDLE.
  - All outputs become 0: busy, prng_seed, prng_mod, prng_start, out_data, out_valid, out_last, fetch_cnt.
  - Buffer, digit counter and remaining length are cleared.
  - Reset mid-operation aborts the operation. A later prng_ready from the core is ignored, because capture happens only in the WAIT states.
- FSM states: IDLE, SEED_REQ, SEED_WAIT, REQ, WAIT, DRAIN.
- IDLE:
  - cfg_seed_load=1 latches cfg_seed into prng_seed and moves to SEED_REQ.
  - Else req_start=1 with req_len!=0 latches req_len and moves to REQ.
  - req_start with req_len=0 is ignored and no prng activity occurs.
  - If cfg_seed_load and req_start arrive in the same cycle, both are latched: seeding runs first, then the burst runs without returning to IDLE.
- SEED_REQ:
  - Outputs are prng_start=1 and prng_mod=1 for exactly one cycle.
  - Next state is SEED_WAIT.
- SEED_WAIT:
  - Waits for prng_ready=1.
  - The word produced by the seed update is discarded and fetch_cnt is not incremented.
  - Next state is REQ if a burst is pending, else IDLE.
- REQ:
  - Outputs are prng_start=1 and prng_mod=0 for one cycle.
  - Next state is WAIT.
- WAIT:
  - On the first cycle with prng_ready=1: capture prng_rng into the buffer, set the digit count to W/DIGIT, increment fetch_cnt, and move to DRAIN.
  - prng_ready is treated as level-sensitive; only the first high cycle in WAIT is used.
- DRAIN:
  - out_valid=1 for the whole state.
  - On each transfer: shift the buffer right by DIGIT, decrement the digit count, decrement the remaining length.
  - out_last = (remaining == 1).
  - After the last transfer: go to IDLE, discarding any unused digits in the buffer.
  - If the digit count reaches 0 while remaining > 0: go to REQ. The next word is not prefetched.
  - out_data/out_valid hold stable while out_accept=0. No chunk is dropped or duplicated.
- Output timing rules:
  - prng_mod is 0 in every cycle where prng_start=0.
  - prng_seed holds its value until the next accepted cfg_seed_load.
- Latency:
  - req_start at edge t gives prng_start high in cycle t+1.
  - prng_ready seen at edge u gives out_valid high in cycle u+1.
  - Each chunk of a buffered word transfers 1 per cycle when out_accept=1.
- Ignored inputs: cfg_seed_load and req_start while busy=1 have no effect and are not queued.
- Arithmetic: remaining length and fetch_cnt are LEN_W-bit unsigned. fetch_cnt wraps from 2^LEN_W-1 to 0.

Test Plan:
- Reset check: drive rst_b=0 for 2 cycles with garbage inputs -> all outputs are 0 and busy=0; assert rst_b=1 -> outputs stay 0 with no requests.
- Seed only: cfg_seed=96'hFFFFFFFF, cfg_seed_load pulse -> exactly one prng_start with prng_mod=1 and prng_seed=96'hFFFFFFFF; after prng_ready, busy returns to 0, out_valid never rises, fetch_cnt=0.
- Single-word burst: req_len=3, prng model returns 96'h000000030000000200000001 -> out_data 1, 2, 3 on consecutive accepted cycles; out_last only on 3; one prng_start with prng_mod=0; fetch_cnt=1.
- Multi-word burst with backpressure: req_len=5, out_accept toggling 1010… -> 5 chunks in order, second prng_start issued only after chunk 3, 1 chunk discarded, out_data stable while out_accept=0, fetch_cnt=2.
- Simultaneous seed+request, busy rejection: same-cycle cfg_seed_load and req_start with req_len=2 -> seed run then data run; a req_start pulsed during DRAIN produces no extra prng_start; a req_start with req_len=0 in IDLE -> no activity.
- Reset mid-WAIT: rst_b=0 after prng_start, prng_ready arrives 3 cycles later -> ignored, out_valid stays 0, fetch_cnt=0.

Source files
------------

// File: rtl/prng_stream_ctrl.sv
// prng_stream_ctrl
//   Initiator-side controller for the prng core. It issues seed updates and
//   word requests to the core, captures each W-bit word, and streams it out
//   as DIGIT-wide chunks (LSB chunk first) over a valid/accept handshake.
//   Bursts are bounded by req_len chunks. A burst may span several PRNG
//   words. Unused chunks of the final word are dropped.
//
// Ports
//   clk, rst_b            clock (rising edge), synchronous active-low reset
//   cfg_seed/_load        reseed value and request pulse (only in IDLE)
//   req_start/req_len     burst request pulse and chunk count (only in IDLE)
//   busy                  high in every state except IDLE
//   prng_seed/mod/start   drive prng in_seed / in_mod / in_ready
//   prng_rng/ready        from prng out_rng / out_ready
//   out_data/valid/last   chunk stream, out_accept is the downstream ready
//   fetch_cnt             PRNG words captured since reset (wraps)
module prng_stream_ctrl #(
  parameter int W     = 96,
  parameter int DIGIT = 32,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic [W-1:0]     cfg_seed,
  input  logic             cfg_seed_load,
  input  logic             req_start,
  input  logic [LEN_W-1:0] req_len,
  output logic             busy,
  output logic [W-1:0]     prng_seed,
  output logic             prng_mod,
  output logic             prng_start,
  input  logic [W-1:0]     prng_rng,
  input  logic             prng_ready,
  output logic [DIGIT-1:0] out_data,
  output logic             out_valid,
  input  logic             out_accept,
  output logic             out_last,
  output logic [LEN_W-1:0] fetch_cnt
);

  localparam int NCH  = W / DIGIT;
  localparam int DC_W = $clog2(NCH + 1);
  localparam logic [DC_W-1:0]  NCH_V  = DC_W'(NCH);
  localparam logic [DC_W-1:0]  DC_ONE = DC_W'(1);
  localparam logic [LEN_W-1:0] L_ONE  = LEN_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_SEED_REQ, S_SEED_WAIT, S_REQ, S_WAIT, S_DRAIN
  } state_t;

  state_t            r_state, w_next;
  logic [W-1:0]      r_buf;
  logic [W-1:0]      r_seed;
  logic [DC_W-1:0]   r_dcnt;
  logic [LEN_W-1:0]  r_rem;
  logic [LEN_W-1:0]  r_fetch;
  logic              r_pend;   // burst latched alongside a reseed

  logic w_burst_ok;
  logic w_xfer;

  assign w_burst_ok = req_start && (req_len != '0);
  assign w_xfer     = (r_state == S_DRAIN) && out_accept;

  // state register
  always_ff @(posedge clk) begin
    if (!rst_b) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (cfg_seed_load)   w_next = S_SEED_REQ;
        else if (w_burst_ok) w_next = S_REQ;
      end
      S_SEED_REQ:  w_next = S_SEED_WAIT;
      S_SEED_WAIT: if (prng_ready) w_next = r_pend ? S_REQ : S_IDLE;
      S_REQ:       w_next = S_WAIT;
      S_WAIT:      if (prng_ready) w_next = S_DRAIN;
      S_DRAIN: begin
        // end of burst wins over end of word: leftover chunks are dropped
        if (w_xfer) begin
          if (r_rem == L_ONE)        w_next = S_IDLE;
          else if (r_dcnt == DC_ONE) w_next = S_REQ;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    busy       = (r_state != S_IDLE);
    prng_start = (r_state == S_SEED_REQ) || (r_state == S_REQ);
    prng_mod   = (r_state == S_SEED_REQ);
    out_valid  = (r_state == S_DRAIN);
    out_last   = (r_state == S_DRAIN) && (r_rem == L_ONE);
  end

  // datapath
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_buf   <= '0;
      r_seed  <= '0;
      r_dcnt  <= '0;
      r_rem   <= '0;
      r_fetch <= '0;
      r_pend  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cfg_seed_load) begin
            r_seed <= cfg_seed;
            r_pend <= w_burst_ok;
            if (w_burst_ok) r_rem <= req_len;
          end else if (w_burst_ok) begin
            r_rem <= req_len;
          end
        end
        // the word returned by a seed update is not delivered
        S_SEED_WAIT: if (prng_ready) r_pend <= 1'b0;
        S_WAIT: begin
          if (prng_ready) begin
            r_buf   <= prng_rng;
            r_dcnt  <= NCH_V;
            r_fetch <= r_fetch + L_ONE;
          end
        end
        S_DRAIN: begin
          if (w_xfer) begin
            r_buf  <= r_buf >> DIGIT;
            r_dcnt <= r_dcnt - DC_ONE;
            r_rem  <= r_rem - L_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign prng_seed = r_seed;
  assign out_data  = r_buf[DIGIT-1:0];
  assign fetch_cnt = r_fetch;

endmodule
